alu_serial: RTL and testbench

ALU_SERIAL -- requirements
Module: alu_serial

---
 rtl/alu_serial.sv | 208 ++++++++++++++++++++
 tb/tb_alu_serial.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
// Slice-serial ALU: processes DATA_W bits per cycle, least significant slice first,
// with the carry/borrow held in a register between beats.
package alu_serial_pkg;
    typedef struct packed {
        logic z;
        logic n;
        logic h;
        logic c;
    } flags_t;
endpackage

module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int BEATS  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              op,
    input  logic                    wide,
    input  logic [DATA_W*BEATS-1:0] op1,
    input  logic [DATA_W*BEATS-1:0] op2,
    input  flags_t                  in_flags,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W*BEATS-1:0] result,
    output flags_t                  out_flags,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    localparam int W  = DATA_W * BEATS;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_CP  = 4'd7;
    localparam logic [3:0] OP_INC = 4'd8;
    localparam logic [3:0] OP_DEC = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic            carry_q, carry_d;
    logic [3:0]      op_q;
    logic            wide_q;
    logic [W-1:0]    op1_q, op2_q;
    flags_t          flags_in_q;
    logic [W-1:0]    result_q, result_d;
    flags_t          out_flags_q, out_flags_d;

    logic            accept;
    logic            last_beat;
    int              off;
    logic [DATA_W-1:0] a, b, slice;
    logic            cin, cout, hout;
    logic [DATA_W:0] add_full, sub_full;
    logic [4:0]      add_lo, sub_lo;
    logic            is_incdec, is_sub_n, is_arith_c, is_logic, is_nop;

    // Handshakes are strict valid/ready: a request transfers on a rising edge where
    // in_valid && in_ready, a result retires on an edge where out_valid && out_ready.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE) && !rst;
    assign busy      = (state_q != S_IDLE) && !rst;
    assign dbg_state = state_q;
    assign result    = result_q;
    assign out_flags = out_flags_q;

    assign accept    = in_valid && in_ready;
    assign last_beat = !wide_q || (beat_q == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_EXEC;
            S_EXEC: if (last_beat) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        is_incdec  = (op_q == OP_INC) || (op_q == OP_DEC);
        is_sub_n   = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP) || (op_q == OP_DEC);
        is_arith_c = (op_q == OP_ADD) || (op_q == OP_ADC) || (op_q == OP_SUB) ||
                     (op_q == OP_SBC) || (op_q == OP_CP);
        is_logic   = (op_q == OP_AND) || (op_q == OP_XOR) || (op_q == OP_OR);
        is_nop     = (op_q > OP_DEC);
    end

    always_comb begin
        off = int'(beat_q) * DATA_W;
        a   = op1_q[off +: DATA_W];
        b   = is_incdec ? '0 : op2_q[off +: DATA_W];
        if (beat_q == '0) begin
            if ((op_q == OP_ADC) || (op_q == OP_SBC)) cin = flags_in_q.c;
            else if (is_incdec)                       cin = 1'b1;
            else                                      cin = 1'b0;
        end else begin
            cin = carry_q;
        end
        add_full = {1'b0, a} + {1'b0, b} + (DATA_W + 1)'(cin);
        sub_full = {1'b0, a} - {1'b0, b} - (DATA_W + 1)'(cin);
        add_lo   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + 5'(cin);
        sub_lo   = {1'b0, a[3:0]} - {1'b0, b[3:0]} - 5'(cin);

        slice = a;
        cout  = 1'b0;
        hout  = 1'b0;
        case (op_q)
            OP_ADD, OP_ADC, OP_INC: begin
                slice = add_full[DATA_W-1:0];
                cout  = add_full[DATA_W];
                hout  = add_lo[4];
            end
            OP_SUB, OP_SBC, OP_DEC: begin
                slice = sub_full[DATA_W-1:0];
                cout  = sub_full[DATA_W];
                hout  = sub_lo[4];
            end
            OP_CP: begin
                slice = a;
                cout  = sub_full[DATA_W];
                hout  = sub_lo[4];
            end
            OP_AND:  slice = a & b;
            OP_XOR:  slice = a ^ b;
            OP_OR:   slice = a | b;
            default: slice = a;
        endcase
    end

    always_comb begin
        beat_d      = beat_q;
        carry_d     = carry_q;
        result_d    = result_q;
        out_flags_d = out_flags_q;
        if (state_q == S_IDLE) begin
            if (accept) begin
                beat_d   = '0;
                carry_d  = 1'b0;
                result_d = '0;
            end
        end else if (state_q == S_EXEC) begin
            carry_d = cout;
            result_d[off +: DATA_W] = slice;
            if (!last_beat) beat_d = beat_q + CW'(1);
            if (last_beat) begin
                // Wide INC/DEC and all NOPs pass the incoming flags through untouched.
                if (is_nop || (wide_q && is_incdec)) begin
                    out_flags_d = flags_in_q;
                end else begin
                    out_flags_d.z = (wide_q && is_arith_c) ? flags_in_q.z : (result_d == '0);
                    out_flags_d.n = is_sub_n;
                    out_flags_d.h = is_logic ? (op_q == OP_AND) : hout;
                    out_flags_d.c = is_arith_c ? cout : (is_incdec ? flags_in_q.c : 1'b0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q      <= '0;
            carry_q     <= 1'b0;
            op_q        <= '0;
            wide_q      <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            flags_in_q  <= '0;
            result_q    <= '0;
            out_flags_q <= '0;
        end else begin
            if (accept) begin
                op_q       <= op;
                wide_q     <= wide;
                op1_q      <= op1;
                op2_q      <= op2;
                flags_in_q <= in_flags;
            end
            beat_q      <= beat_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            out_flags_q <= out_flags_d;
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// Directed bench for alu_serial (DATA_W=8, BEATS=2): hand-computed vectors,
// backpressure hold and mid-operation reset abort.
module tb_alu_serial;
    import alu_serial_pkg::*;

    localparam int DATA_W = 8;
    localparam int BEATS  = 2;
    localparam int W      = DATA_W * BEATS;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic         wide;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    flags_t       in_flags;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    flags_t       out_flags;
    logic         busy;
    logic [1:0]   dbg_state;
    logic [3:0]   of_bits;

    int n_vec = 0;
    int n_err = 0;

    assign of_bits = out_flags;

    alu_serial #(.DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .wide      (wide),
        .op1       (op1),
        .op2       (op2),
        .in_flags  (in_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_flags (out_flags),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Flags are written {z,n,h,c}.
    task automatic run_tx(input string tag, input logic [3:0] t_op, input logic t_wide,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] fin,
                          input logic [W-1:0] exp_res, input logic [3:0] exp_fl);
        int lat;
        int exp_lat;
        exp_lat  = t_wide ? BEATS + 1 : 2;
        op       = t_op;
        wide     = t_wide;
        op1      = a;
        op2      = b;
        in_flags = fin;
        in_valid = 1'b1;
        check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        op       = 4'($urandom_range(0, 15));
        wide     = 1'($urandom_range(0, 1));
        op1      = 16'($urandom);
        op2      = 16'($urandom);
        in_flags = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/result"}, 32'(result), 32'(exp_res));
        check({tag, "/flags"}, 32'(of_bits), 32'(exp_fl));
        check({tag, "/busy"}, 32'(busy), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "/out_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "/in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'd0;
        wide      = 1'b0;
        op1       = '0;
        op2       = '0;
        in_flags  = '0;

        @(negedge clk);
        @(negedge clk);
        check("rst/in_ready", 32'(in_ready), 32'd0);
        check("rst/out_valid", 32'(out_valid), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/result", 32'(result), 32'd0);
        check("rst/flags", 32'(of_bits), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_rel/in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        run_tx("add_single", 4'd0, 1'b0, 16'h003A, 16'h00C6, 4'b0000, 16'h0000, 4'b1011);
        run_tx("add_wide",   4'd0, 1'b1, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010);
        run_tx("sbc_wide",   4'd3, 1'b1, 16'h1000, 16'h0001, 4'b0001, 16'h0FFE, 4'b0110);
        run_tx("sbc_wide_z", 4'd3, 1'b1, 16'h1000, 16'h0001, 4'b1001, 16'h0FFE, 4'b1110);
        run_tx("dec_wide",   4'd9, 1'b1, 16'h0000, 16'h1234, 4'b1011, 16'hFFFF, 4'b1011);
        run_tx("sub_single", 4'd2, 1'b0, 16'hAB10, 16'hCD01, 4'b0000, 16'h000F, 4'b0110);
        run_tx("and_single", 4'd4, 1'b0, 16'h00F0, 16'h000F, 4'b0000, 16'h0000, 4'b1010);
        run_tx("xor_wide",   4'd5, 1'b1, 16'h1234, 16'h1234, 4'b0000, 16'h0000, 4'b1000);
        run_tx("or_wide",    4'd6, 1'b1, 16'h0100, 16'h0000, 4'b1111, 16'h0100, 4'b0000);
        run_tx("inc_single", 4'd8, 1'b0, 16'h00FF, 16'h0000, 4'b0000, 16'h0000, 4'b1010);
        run_tx("nop_single", 4'd12, 1'b0, 16'h5AA5, 16'h0000, 4'b0101, 16'h00A5, 4'b0101);
        run_tx("adc_wide",   4'd1, 1'b1, 16'h00FF, 16'h0000, 4'b0001, 16'h0100, 4'b0000);
        run_tx("add_wrap",   4'd0, 1'b1, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011);

        // Backpressure: result held in DONE while a stray request is ignored.
        op = 4'd0; wide = 1'b0; op1 = 16'h0001; op2 = 16'h0002; in_flags = 4'b0000;
        in_valid = 1'b1;
        check("bp/in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("bp/latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("bp/hold_valid", 32'(out_valid), 32'd1);
            check("bp/hold_result", 32'(result), 32'h0003);
            check("bp/hold_flags", 32'(of_bits), 32'h0);
            check("bp/hold_in_ready", 32'(in_ready), 32'd0);
            if (i == 2) begin
                in_valid = 1'b1; op = 4'd2; wide = 1'b1; op1 = 16'hFFFF; op2 = 16'h0001;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp/idle_valid", 32'(out_valid), 32'd0);
        check("bp/idle_ready", 32'(in_ready), 32'd1);
        check("bp/idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("bp/pulse_ignored", 32'(busy), 32'd0);
        check("bp/result_kept", 32'(result), 32'h0003);

        // Reset after wide beat 0 aborts the operation.
        op = 4'd0; wide = 1'b1; op1 = 16'h1111; op2 = 16'h2222; in_flags = 4'b0000;
        in_valid = 1'b1;
        check("abort/in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("abort/beat0_result", 32'(result), 32'h0033);
        check("abort/beat0_valid", 32'(out_valid), 32'd0);
        check("abort/beat0_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort/result", 32'(result), 32'd0);
        check("abort/flags", 32'(of_bits), 32'd0);
        check("abort/out_valid", 32'(out_valid), 32'd0);
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort/rel_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("abort/no_valid", 32'(out_valid), 32'd0);
        check("abort/still_ready", 32'(in_ready), 32'd1);
        run_tx("after_abort", 4'd2, 1'b1, 16'h0100, 16'h0001, 4'b0000, 16'h00FF, 4'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
